// File: rtl/cv32e41p_apu_responder_pkg.sv
// rtl/cv32e41p_apu_responder_pkg.sv - shared op codes, flag indices and LFSR constants for the APU responder
package cv32e41p_apu_responder_pkg;

    typedef enum logic [2:0] {
        APU_OP_ADD = 3'd0,
        APU_OP_SUB = 3'd1,
        APU_OP_MUL = 3'd2,
        APU_OP_MAC = 3'd3,
        APU_OP_MIN = 3'd4,
        APU_OP_MAX = 3'd5,
        APU_OP_AND = 3'd6,
        APU_OP_XOR = 3'd7
    } apu_op_e;

    localparam int APU_NFLAGS   = 5;
    localparam int APU_FLG_ZERO = 0;
    localparam int APU_FLG_OVF  = 1;
    localparam int APU_FLG_NEG  = 2;
    localparam int APU_FLG_ILL  = 4;

    // Fibonacci taps 16,14,13,11 expressed as a mask over bits [15:0]
    localparam logic [15:0] APU_LFSR_SEED = 16'hACE1;
    localparam logic [15:0] APU_LFSR_TAPS = 16'hB400;

    function automatic logic [APU_NFLAGS-1:0] apu_illegal_flags();
        logic [APU_NFLAGS-1:0] f;
        f = '0;
        f[APU_FLG_ILL]  = 1'b1;
        f[APU_FLG_ZERO] = 1'b1;
        return f;
    endfunction

endpackage

// File: rtl/cv32e41p_apu_responder_alu.sv
// rtl/cv32e41p_apu_responder_alu.sv - combinational op/operands to result and result flags
module cv32e41p_apu_responder_alu
    import cv32e41p_apu_responder_pkg::*;
(
    input  logic [5:0]            i_op,
    input  logic [31:0]           i_a,
    input  logic [31:0]           i_b,
    input  logic [31:0]           i_c,
    output logic [31:0]           o_result,
    output logic [APU_NFLAGS-1:0] o_flags
);

    apu_op_e     w_op;
    logic        w_illegal;
    logic [31:0] w_sum;
    logic [31:0] w_diff;
    logic [31:0] w_res;
    logic        w_ovf;

    assign w_op      = apu_op_e'(i_op[2:0]);
    assign w_illegal = (i_op[5:3] != 3'b000);
    assign w_sum     = i_a + i_b;
    assign w_diff    = i_a - i_b;

    always_comb begin
        w_res = '0;
        w_ovf = 1'b0;
        case (w_op)
            APU_OP_ADD: begin
                w_res = w_sum;
                w_ovf = (i_a[31] == i_b[31]) && (w_sum[31] != i_a[31]);
            end
            APU_OP_SUB: begin
                w_res = w_diff;
                w_ovf = (i_a[31] != i_b[31]) && (w_diff[31] != i_a[31]);
            end
            APU_OP_MUL: w_res = i_a * i_b;
            APU_OP_MAC: w_res = i_a * i_b + i_c;
            APU_OP_MIN: w_res = ($signed(i_a) < $signed(i_b)) ? i_a : i_b;
            APU_OP_MAX: w_res = ($signed(i_a) < $signed(i_b)) ? i_b : i_a;
            APU_OP_AND: w_res = i_a & i_b;
            APU_OP_XOR: w_res = i_a ^ i_b;
            default:    w_res = '0;
        endcase
    end

    always_comb begin
        o_result = '0;
        o_flags  = '0;
        if (w_illegal) begin
            o_flags = apu_illegal_flags();
        end else begin
            o_result               = w_res;
            o_flags[APU_FLG_ZERO]  = (w_res == 32'd0);
            o_flags[APU_FLG_OVF]   = w_ovf;
            o_flags[APU_FLG_NEG]   = w_res[31];
        end
    end

endmodule

// File: rtl/cv32e41p_apu_responder.sv
// rtl/cv32e41p_apu_responder.sv - APU responder: req/gnt handshake, fixed-latency in-order result pipe (optional CV32E41P_APU_RESPONDER_STALL_EN)
module cv32e41p_apu_responder
    import cv32e41p_apu_responder_pkg::*;
#(
    parameter int LATENCY         = 2,
    parameter int MAX_OUTSTANDING = 2,
    parameter int WAPU            = 6
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  apu_req_i,
    output logic                  apu_gnt_o,
    input  logic [5:0]            apu_op_i,
    input  logic [2:0][31:0]      apu_operands_i,
    input  logic [14:0]           apu_flags_i,
    input  logic [WAPU-1:0]       apu_waddr_i,
    output logic                  apu_rvalid_o,
    output logic [31:0]           apu_result_o,
    output logic [APU_NFLAGS-1:0] apu_flags_o,
    output logic [WAPU-1:0]       apu_waddr_o,
    output logic                  busy_o
);

    localparam int CW = $clog2(MAX_OUTSTANDING + 1);

    logic [CW-1:0]         r_count;
    logic [LATENCY-1:0]    r_vld;
    logic [31:0]           r_res [LATENCY];
    logic [APU_NFLAGS-1:0] r_flg [LATENCY];
    logic [WAPU-1:0]       r_wad [LATENCY];

    logic                  w_accept;
    logic                  w_rvalid;
    logic                  w_slot_free;
    logic                  w_stall;
    logic [31:0]           w_alu_result;
    logic [APU_NFLAGS-1:0] w_alu_flags;
    logic                  w_unused_flags;

    assign w_unused_flags = ^apu_flags_i;

`ifdef CV32E41P_APU_RESPONDER_STALL_EN
    logic [15:0] r_lfsr;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_lfsr <= APU_LFSR_SEED;
        end else begin
            r_lfsr <= {r_lfsr[14:0], ^(r_lfsr & APU_LFSR_TAPS)};
        end
    end

    assign w_stall = (r_lfsr[1:0] == 2'b00);
`else
    assign w_stall = 1'b0;
`endif

    // Count is registered, so a slot freed by rvalid is only re-granted next cycle
    assign w_slot_free = (r_count < CW'(MAX_OUTSTANDING));
    assign apu_gnt_o   = apu_req_i && !rst_i && w_slot_free && !w_stall;
    assign w_accept    = apu_req_i && apu_gnt_o;
    assign w_rvalid    = r_vld[LATENCY-1];

    cv32e41p_apu_responder_alu u_alu (
        .i_op     (apu_op_i),
        .i_a      (apu_operands_i[0]),
        .i_b      (apu_operands_i[1]),
        .i_c      (apu_operands_i[2]),
        .o_result (w_alu_result),
        .o_flags  (w_alu_flags)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_count <= '0;
        end else begin
            case ({w_accept, w_rvalid})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Payload moves only with a valid entry, so the last stage holds the last result
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_vld <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                r_res[i] <= '0;
                r_flg[i] <= '0;
                r_wad[i] <= '0;
            end
        end else begin
            r_vld[0] <= w_accept;
            if (w_accept) begin
                r_res[0] <= w_alu_result;
                r_flg[0] <= w_alu_flags;
                r_wad[0] <= apu_waddr_i;
            end
            for (int i = 1; i < LATENCY; i++) begin
                r_vld[i] <= r_vld[i-1];
                if (r_vld[i-1]) begin
                    r_res[i] <= r_res[i-1];
                    r_flg[i] <= r_flg[i-1];
                    r_wad[i] <= r_wad[i-1];
                end
            end
        end
    end

    assign apu_rvalid_o = w_rvalid;
    assign apu_result_o = r_res[LATENCY-1];
    assign apu_flags_o  = r_flg[LATENCY-1];
    assign apu_waddr_o  = r_wad[LATENCY-1];
    assign busy_o       = (r_count != '0);

endmodule

// File: tb/tb_cv32e41p_apu_responder.sv
// tb/tb_cv32e41p_apu_responder.sv - scoreboard bench for cv32e41p_apu_responder (honours CV32E41P_APU_RESPONDER_STALL_EN)
module tb_cv32e41p_apu_responder;

    localparam int LAT  = 2;
    localparam int MAXO = 2;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  flg;
        logic [5:0]  wa;
        int          cyc;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            req = 1'b0;
    logic            gnt;
    logic [5:0]      op_i = '0;
    logic [2:0][31:0] opnds = '0;
    logic [14:0]     flags_i = '0;
    logic [5:0]      waddr_i = '0;
    logic            rvalid;
    logic [31:0]     result;
    logic [4:0]      flags_o;
    logic [5:0]      waddr_o;
    logic            busy;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    exp_t sbq[$];
    bit   acc_at[int];
    logic [31:0] last_res = '0;
    logic [4:0]  last_flg = '0;
    logic [5:0]  last_wa  = '0;
    logic [15:0] m_lfsr = 16'hACE1;
    int   m_outst;
    logic m_gnt;

    cv32e41p_apu_responder #(.LATENCY(LAT), .MAX_OUTSTANDING(MAXO), .WAPU(6)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .apu_req_i      (req),
        .apu_gnt_o      (gnt),
        .apu_op_i       (op_i),
        .apu_operands_i (opnds),
        .apu_flags_i    (flags_i),
        .apu_waddr_i    (waddr_i),
        .apu_rvalid_o   (rvalid),
        .apu_result_o   (result),
        .apu_flags_o    (flags_o),
        .apu_waddr_o    (waddr_o),
        .busy_o         (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) m_lfsr <= 16'hACE1;
        else     m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Reference: spec arithmetic on wide signed/unsigned integers
    function automatic logic [36:0] ref_model(input logic [5:0] op, input logic [31:0] a,
                                              input logic [31:0] b, input logic [31:0] c);
        longint sa, sb, full;
        logic [31:0] r;
        logic ovf;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ovf = 1'b0;
        r = '0;
        if (op[5:3] != 3'b000) return {5'b10001, 32'd0};
        case (op[2:0])
            3'd0: begin full = sa + sb; r = full[31:0]; ovf = (full != longint'($signed(r))); end
            3'd1: begin full = sa - sb; r = full[31:0]; ovf = (full != longint'($signed(r))); end
            3'd2: begin full = longint'(a) * longint'(b); r = full[31:0]; end
            3'd3: begin full = longint'(a) * longint'(b) + longint'(c); r = full[31:0]; end
            3'd4: r = (sa < sb) ? a : b;
            3'd5: r = (sa > sb) ? a : b;
            3'd6: r = a & b;
            default: r = a ^ b;
        endcase
        return {1'b0, 1'b0, r[31], ovf, (r == 32'd0), r};
    endfunction

    always @(negedge clk) begin
        exp_t e;
        m_outst = 0;
        for (int k = 1; k <= LAT; k++) if (acc_at.exists(cyc - k)) m_outst++;
        m_gnt = req && !rst && (m_outst < MAXO);
`ifdef CV32E41P_APU_RESPONDER_STALL_EN
        if (m_lfsr[1:0] == 2'b00) m_gnt = 1'b0;
`endif
        chk("gnt", 32'(gnt), 32'(m_gnt));
        if (!rst) chk("busy", 32'(busy), 32'(m_outst != 0));
        if (rvalid === 1'b1) begin
            if (sbq.size() == 0) begin
                chk("spurious_rvalid", 32'(rvalid), 32'd0);
            end else begin
                e = sbq.pop_front();
                chk("latency", cyc, e.cyc);
                chk("result", result, e.res);
                chk("flags", 32'(flags_o), 32'(e.flg));
                chk("waddr", 32'(waddr_o), 32'(e.wa));
                last_res = e.res; last_flg = e.flg; last_wa = e.wa;
            end
        end else begin
            chk("rvalid_low", 32'(rvalid), 32'd0);
            chk("hold_result", result, last_res);
            chk("hold_flags", 32'(flags_o), 32'(last_flg));
            chk("hold_waddr", 32'(waddr_o), 32'(last_wa));
            if (sbq.size() != 0 && sbq[0].cyc <= cyc) begin
                chk("missing_rvalid", 32'(rvalid), 32'd1);
                void'(sbq.pop_front());
            end
        end
        if (rst) begin
            last_res = '0; last_flg = '0; last_wa = '0;
        end
    end

    task automatic issue(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] c, input logic [5:0] wa, input bit fixed,
                         input logic [31:0] xr, input logic [4:0] xf, output int acc);
        logic [36:0] m;
        exp_t e;
        bit got;
        @(posedge clk); #1;
        rst = 1'b0; req = 1'b1; op_i = op;
        opnds[0] = a; opnds[1] = b; opnds[2] = c;
        waddr_i = wa; flags_i = 15'($urandom);
        got = 1'b0;
        acc = -1;
        for (int w = 0; w < 50 && !got; w++) begin
            @(negedge clk);
            if (gnt === 1'b1) begin
                got = 1'b1;
                acc = cyc;
                m = ref_model(op, a, b, c);
                e.res = fixed ? xr : m[31:0];
                e.flg = fixed ? xf : m[36:32];
                e.wa  = wa;
                e.cyc = cyc + LAT;
                sbq.push_back(e);
                acc_at[cyc] = 1'b1;
            end else begin
                @(posedge clk); #1;
            end
        end
        if (!got) begin
            checks++; errors++;
            $display("FAIL grant_timeout at cycle %0d: got no grant expected grant within 50 cycles", cyc);
        end
    endtask

    task automatic idle(input int n);
        @(posedge clk); #1;
        req = 1'b0;
        repeat (n - 1) @(posedge clk);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'h7FFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not end, expected end within time limit");
        $fatal(1);
    end

    initial begin
        int c0, c1, c2, rc, d;
        logic [5:0] rop;
        int nrand;

        req = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        req = 1'b0;
        chk("reset_rvalid", 32'(rvalid), 32'd0);
        chk("reset_result", result, 32'd0);
        chk("reset_flags", 32'(flags_o), 32'd0);
        chk("reset_waddr", 32'(waddr_o), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);

        issue(6'd0, 32'd5, 32'd7, 32'd0, 6'd3, 1'b1, 32'd12, 5'b00000, c0);
        idle(5);

        issue(6'd0, 32'd1, 32'd1, 32'd0, 6'd4, 1'b1, 32'd2, 5'b00000, c0);
        issue(6'd1, 32'd1, 32'd1, 32'd0, 6'd5, 1'b1, 32'd0, 5'b00001, c1);
        issue(6'd3, 32'd3, 32'd4, 32'd5, 6'd6, 1'b1, 32'd17, 5'b00000, c2);
`ifndef CV32E41P_APU_RESPONDER_STALL_EN
        chk("b2b_second_accept", c1, c0 + 1);
        chk("b2b_third_stall", c2, c0 + 3);
`endif
        idle(5);

        issue(6'd0, 32'h7FFF_FFFF, 32'd1, 32'd0, 6'd7, 1'b1, 32'h8000_0000, 5'b00110, c0);
        issue(6'd4, 32'hFFFF_FFFF, 32'd1, 32'd0, 6'd8, 1'b1, 32'hFFFF_FFFF, 5'b00100, c0);
        issue(6'h08, $urandom, $urandom, $urandom, 6'h21, 1'b1, 32'd0, 5'b10001, c0);
        idle(5);

        issue(6'd0, 32'd9, 32'd9, 32'd0, 6'd9, 1'b1, 32'd18, 5'b00000, c0);
        @(posedge clk); #1;
        req = 1'b0; rst = 1'b1;
        sbq.delete();
        acc_at.delete();
        rc = cyc;
        issue(6'd7, 32'hF0F0_0000, 32'h0FF0_0000, 32'd0, 6'd10, 1'b1, 32'hFF00_0000, 5'b00100, c0);
`ifndef CV32E41P_APU_RESPONDER_STALL_EN
        chk("grant_after_reset", c0, rc + 1);
`endif
        idle(5);

`ifdef CV32E41P_APU_RESPONDER_STALL_EN
        nrand = 1000;
`else
        nrand = 300;
`endif
        for (int i = 0; i < nrand; i++) begin
            rop = ($urandom_range(0, 7) == 0) ? 6'($urandom_range(8, 63)) : 6'($urandom_range(0, 7));
            issue(rop, pick(), pick(), pick(), 6'($urandom), 1'b0, 32'd0, 5'd0, c0);
`ifndef CV32E41P_APU_RESPONDER_STALL_EN
            if ($urandom_range(0, 3) == 0) begin
                d = $urandom_range(1, 3);
                idle(d);
            end
`endif
        end
        idle(2);

        for (int w = 0; w < 20 && sbq.size() != 0; w++) @(posedge clk);
        chk("drain", sbq.size(), 0);
        repeat (2) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
